// File: rtl/aes_mmio_slave_pkg.sv
// aes_mmio_pkg: address map, register bit positions and controller state
// encoding shared by the AES MMIO responder and its command sequencer.
package aes_mmio_pkg;

   // Word addresses of the register bank
   localparam int ADDR_CTRL    = 'h08;
   localparam int ADDR_STATUS  = 'h09;
   localparam int ADDR_CONFIG  = 'h0A;
   localparam int ADDR_KEY0    = 'h10;
   localparam int ADDR_BLOCK0  = 'h20;
   localparam int ADDR_RESULT0 = 'h30;

   localparam int NUM_KEY_WORDS   = 8;
   localparam int NUM_BLOCK_WORDS = 4;

   // CTRL bits (write-only command pulses)
   localparam int CTRL_INIT_BIT = 0;
   localparam int CTRL_NEXT_BIT = 1;

   // STATUS bits
   localparam int STAT_READY_BIT = 0;
   localparam int STAT_VALID_BIT = 1;

   // CONFIG bits
   localparam int CFG_ENCDEC_BIT = 0;
   localparam int CFG_KEYLEN_BIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      NEXT = 2'd2
   } aes_state_e;

endpackage

// File: rtl/aes_mmio_slave_if.sv
// aes_mmio_slave_if: single-cycle request / next-cycle acknowledge data bus
// between the CPU load/store path (master) and the AES responder (slave).
interface aes_mmio_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req_i;
   logic              we_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              ack_o;
   logic [DATA_W-1:0] rdata_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ack_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ack_o, rdata_o
   );
endinterface

// File: rtl/aes_mmio_slave_ctrl_fsm.sv
// aes_ctrl_fsm: sequences the AES core through its init/next handshake.
// Accepts CTRL commands only in IDLE (init beats next), emits one-cycle
// start pulses and flags the cycle in which the core result is captured.
module aes_ctrl_fsm
   import aes_mmio_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_wr_i,
   input  logic       init_req_i,
   input  logic       next_req_i,
   input  logic       core_ready_i,
   input  logic       core_result_valid_i,
   output aes_state_e state_o,
   output logic       core_init_o,
   output logic       core_next_o,
   output logic       cmd_acc_o,
   output logic       capture_o
);

   aes_state_e state_q, state_d;
   logic       init_acc, next_acc;
   logic       init_q, next_q;

   // State register and registered start pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         init_q  <= 1'b0;
         next_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= init_acc;
         next_q  <= next_acc;
      end
   end

   // Next-state, command acceptance and result-capture decode
   always_comb begin
      state_d   = state_q;
      init_acc  = 1'b0;
      next_acc  = 1'b0;
      capture_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_wr_i) begin
               if (init_req_i) begin
                  init_acc = 1'b1;
                  state_d  = INIT;
               end else if (next_req_i) begin
                  next_acc = 1'b1;
                  state_d  = NEXT;
               end
            end
         end
         // Ready is not trusted during the pulse cycle itself: the core
         // has not yet seen the init request.
         INIT: begin
            if (!init_q && core_ready_i) begin
               state_d = IDLE;
            end
         end
         NEXT: begin
            if (core_result_valid_i) begin
               capture_o = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state_o     = state_q;
   assign core_init_o = init_q;
   assign core_next_o = next_q;
   assign cmd_acc_o   = init_acc | next_acc;

endmodule

// File: rtl/aes_mmio_slave.sv
// aes_mmio_slave: memory-mapped responder for the AES accelerator. Holds the
// key/block/result/config register bank, answers every bus access one cycle
// later, and drives the AES core through aes_ctrl_fsm.
// Build option AES_KEY_READBACK_EN: when defined, KEY0..7 read back the
// stored key; otherwise the key is write-only and KEY reads return 0.
module aes_mmio_slave
   import aes_mmio_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   aes_mmio_slave_if.slave       bus,
   output logic                  core_init_o,
   output logic                  core_next_o,
   output logic                  core_encdec_o,
   output logic                  core_keylen_o,
   output logic [8*DATA_W-1:0]   core_key_o,
   output logic [4*DATA_W-1:0]   core_block_o,
   input  logic                  core_ready_i,
   input  logic [4*DATA_W-1:0]   core_result_i,
   input  logic                  core_result_valid_i
);

   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ADDR_CTRL);
   localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(ADDR_STATUS);
   localparam logic [ADDR_W-1:0] A_CONFIG  = ADDR_W'(ADDR_CONFIG);
   localparam logic [ADDR_W-1:0] A_KEY0    = ADDR_W'(ADDR_KEY0);
   localparam logic [ADDR_W-1:0] A_BLOCK0  = ADDR_W'(ADDR_BLOCK0);
   localparam logic [ADDR_W-1:0] A_RESULT0 = ADDR_W'(ADDR_RESULT0);

   logic [DATA_W-1:0] key_q    [NUM_KEY_WORDS];
   logic [DATA_W-1:0] block_q  [NUM_BLOCK_WORDS];
   logic [DATA_W-1:0] result_q [NUM_BLOCK_WORDS];
   logic              encdec_q, keylen_q, valid_q;
   logic              ack_q;
   logic [DATA_W-1:0] rdata_q, rd_mux;

   aes_state_e state;
   logic       cmd_acc, capture, is_idle;
   logic       sel_ctrl, sel_status, sel_config, sel_key, sel_block, sel_result;
   logic       wr_ok, cmd_wr;
   logic [2:0] key_idx;
   logic [1:0] blk_idx;

   // KEY spans 8 aligned words, BLOCK and RESULT 4 aligned words each
   assign sel_ctrl   = (bus.addr_i == A_CTRL);
   assign sel_status = (bus.addr_i == A_STATUS);
   assign sel_config = (bus.addr_i == A_CONFIG);
   assign sel_key    = (bus.addr_i[ADDR_W-1:3] == A_KEY0[ADDR_W-1:3]);
   assign sel_block  = (bus.addr_i[ADDR_W-1:2] == A_BLOCK0[ADDR_W-1:2]);
   assign sel_result = (bus.addr_i[ADDR_W-1:2] == A_RESULT0[ADDR_W-1:2]);
   assign key_idx    = bus.addr_i[2:0];
   assign blk_idx    = bus.addr_i[1:0];

   assign is_idle = (state == IDLE);
   assign cmd_wr  = bus.req_i && bus.we_i && sel_ctrl;
   assign wr_ok   = bus.req_i && bus.we_i && is_idle;

   aes_ctrl_fsm u_fsm (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .cmd_wr_i            (cmd_wr),
      .init_req_i          (bus.wdata_i[CTRL_INIT_BIT]),
      .next_req_i          (bus.wdata_i[CTRL_NEXT_BIT]),
      .core_ready_i        (core_ready_i),
      .core_result_valid_i (core_result_valid_i),
      .state_o             (state),
      .core_init_o         (core_init_o),
      .core_next_o         (core_next_o),
      .cmd_acc_o           (cmd_acc),
      .capture_o           (capture)
   );

   // Register bank: software writes only land while idle; result capture
   // and valid tracking follow the sequencer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_KEY_WORDS; i++) key_q[i] <= '0;
         for (int i = 0; i < NUM_BLOCK_WORDS; i++) begin
            block_q[i]  <= '0;
            result_q[i] <= '0;
         end
         encdec_q <= 1'b0;
         keylen_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (cmd_acc) begin
            valid_q <= 1'b0;
         end
         if (capture) begin
            for (int i = 0; i < NUM_BLOCK_WORDS; i++) begin
               result_q[i] <= core_result_i[(NUM_BLOCK_WORDS-1-i)*DATA_W +: DATA_W];
            end
            valid_q <= 1'b1;
         end
         if (wr_ok) begin
            if (sel_config) begin
               encdec_q <= bus.wdata_i[CFG_ENCDEC_BIT];
               keylen_q <= bus.wdata_i[CFG_KEYLEN_BIT];
            end
            if (sel_key) begin
               key_q[key_idx] <= bus.wdata_i;
            end
            if (sel_block) begin
               block_q[blk_idx] <= bus.wdata_i;
            end
         end
      end
   end

   // Read data selection; CTRL and unmapped addresses read as zero
   always_comb begin
      rd_mux = '0;
      if (sel_status) begin
         rd_mux[STAT_READY_BIT] = is_idle;
         rd_mux[STAT_VALID_BIT] = valid_q;
      end else if (sel_config) begin
         rd_mux[CFG_ENCDEC_BIT] = encdec_q;
         rd_mux[CFG_KEYLEN_BIT] = keylen_q;
      end else if (sel_key) begin
`ifdef AES_KEY_READBACK_EN
         rd_mux = key_q[key_idx];
`else
         rd_mux = '0;
`endif
      end else if (sel_block) begin
         rd_mux = block_q[blk_idx];
      end else if (sel_result) begin
         rd_mux = result_q[blk_idx];
      end
   end

   // Bus response: ack every request next cycle, read data only with ack
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= bus.req_i;
         rdata_q <= (bus.req_i && !bus.we_i) ? rd_mux : '0;
      end
   end

   assign bus.ack_o   = ack_q;
   assign bus.rdata_o = rdata_q;

   assign core_encdec_o = encdec_q;
   assign core_keylen_o = keylen_q;

   // KEY0 / BLOCK0 occupy the most significant word of the core vectors
   for (genvar i = 0; i < NUM_KEY_WORDS; i++) begin : g_key
      assign core_key_o[(NUM_KEY_WORDS-1-i)*DATA_W +: DATA_W] = key_q[i];
   end
   for (genvar i = 0; i < NUM_BLOCK_WORDS; i++) begin : g_block
      assign core_block_o[(NUM_BLOCK_WORDS-1-i)*DATA_W +: DATA_W] = block_q[i];
   end

endmodule

// File: tb/tb_aes_mmio_slave.sv
// tb_aes_mmio_slave: directed bench for aes_mmio_slave with a hand-driven
// AES core model; expected values are written out explicitly below.
module tb_aes_mmio_slave;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         core_init_o, core_next_o, core_encdec_o, core_keylen_o;
   logic [255:0] core_key_o;
   logic [127:0] core_block_o;
   logic         core_ready_i;
   logic [127:0] core_result_i;
   logic         core_result_valid_i;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] rd;
   logic        ak;
   logic [31:0] exp_key_rd;

   aes_mmio_slave_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   aes_mmio_slave #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .bus                 (bus),
      .core_init_o         (core_init_o),
      .core_next_o         (core_next_o),
      .core_encdec_o       (core_encdec_o),
      .core_keylen_o       (core_keylen_o),
      .core_key_o          (core_key_o),
      .core_block_o        (core_block_o),
      .core_ready_i        (core_ready_i),
      .core_result_i       (core_result_i),
      .core_result_valid_i (core_result_valid_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Starts #1 after an edge, issues one request, returns #1 after the next
   // edge with the acknowledge and read data of that request.
   task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output logic ackd);
      bus.req_i   = 1'b1;
      bus.we_i    = we;
      bus.addr_i  = a;
      bus.wdata_i = d;
      @(posedge clk_i);
      #1;
      bus.req_i   = 1'b0;
      bus.we_i    = 1'b0;
      bus.wdata_i = '0;
      ackd = bus.ack_o;
      rdat = bus.rdata_o;
   endtask

   initial begin
`ifdef AES_KEY_READBACK_EN
      exp_key_rd = 32'h2B7E1516;
`else
      exp_key_rd = 32'h0000_0000;
`endif
      rst_i               = 1'b1;
      bus.req_i           = 1'b0;
      bus.we_i            = 1'b0;
      bus.addr_i          = '0;
      bus.wdata_i         = '0;
      core_ready_i        = 1'b1;
      core_result_i       = '0;
      core_result_valid_i = 1'b0;
      tick(3);

      // Reset state
      check("rst_ack", bus.ack_o, 0);
      check("rst_rdata", bus.rdata_o, 0);
      check("rst_init", core_init_o, 0);
      check("rst_next", core_next_o, 0);
      check("rst_key", core_key_o, 0);
      check("rst_block", core_block_o, 0);
      check("rst_cfg", {core_keylen_o, core_encdec_o}, 0);
      rst_i = 1'b0;
      tick(1);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("rst_status_ack", ak, 1);
      check("rst_status", rd, 32'h1);
      tick(1);
      check("ack_one_cycle", bus.ack_o, 0);
      check("rdata_idle_zero", bus.rdata_o, 0);

      // Key/block/config load
      xfer(1'b1, 8'h10, 32'h2B7E1516, rd, ak);
      check("key0_wr_ack", ak, 1);
      check("key0_core", core_key_o[255:224], 32'h2B7E1516);
      check("wr_rdata_zero", rd, 0);
      xfer(1'b1, 8'h20, 32'h6BC1BEE2, rd, ak);
      check("block0_core", core_block_o[127:96], 32'h6BC1BEE2);
      xfer(1'b1, 8'h0A, 32'h1, rd, ak);
      check("cfg_encdec", core_encdec_o, 1);
      check("cfg_keylen", core_keylen_o, 0);
      xfer(1'b0, 8'h0A, 0, rd, ak);
      check("cfg_rd", rd, 32'h1);
      xfer(1'b0, 8'h20, 0, rd, ak);
      check("block0_rd", rd, 32'h6BC1BEE2);
      xfer(1'b0, 8'h10, 0, rd, ak);
      check("key0_rd", rd, exp_key_rd);
      xfer(1'b1, 8'h40, 32'hDEADBEEF, rd, ak);
      check("unmapped_wr_ack", ak, 1);
      xfer(1'b0, 8'h40, 0, rd, ak);
      check("unmapped_rd_ack", ak, 1);
      check("unmapped_rd", rd, 0);

      // Init command: single pulse, busy status while waiting
      core_ready_i = 1'b0;
      xfer(1'b1, 8'h08, 32'h1, rd, ak);
      check("init_pulse", core_init_o, 1);
      check("init_no_next", core_next_o, 0);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("init_status_busy", rd, 32'h0);
      check("init_pulse_end", core_init_o, 0);
      core_ready_i = 1'b1;
      tick(1);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("init_done_status", rd, 32'h1);

      // Next command, busy protection, result capture
      xfer(1'b1, 8'h08, 32'h2, rd, ak);
      check("next_pulse", core_next_o, 1);
      check("next_no_init", core_init_o, 0);
      xfer(1'b1, 8'h10, 32'hFFFFFFFF, rd, ak);
      check("busy_key_ack", ak, 1);
      check("next_pulse_end", core_next_o, 0);
      xfer(1'b1, 8'h08, 32'h1, rd, ak);
      check("busy_ctrl_ack", ak, 1);
      check("busy_no_init", core_init_o, 0);
      check("busy_key_kept", core_key_o[255:224], 32'h2B7E1516);
      xfer(1'b1, 8'h0A, 32'h2, rd, ak);
      check("busy_cfg_kept", {core_keylen_o, core_encdec_o}, 2'b01);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("next_status_busy", rd, 32'h0);
      core_result_i       = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
      core_result_valid_i = 1'b1;
      tick(1);
      core_result_valid_i = 1'b0;
      core_result_i       = '0;
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("result_status", rd, 32'h3);
      xfer(1'b0, 8'h30, 0, rd, ak);
      check("result0", rd, 32'h3AD77BB4);
      xfer(1'b0, 8'h33, 0, rd, ak);
      check("result3", rd, 32'h2466EF97);
      xfer(1'b1, 8'h30, 32'h12345678, rd, ak);
      xfer(1'b0, 8'h30, 0, rd, ak);
      check("result_ro", rd, 32'h3AD77BB4);
      xfer(1'b0, 8'h08, 0, rd, ak);
      check("ctrl_rd_zero", rd, 0);

      // Simultaneous init+next: init wins, valid clears
      core_ready_i = 1'b0;
      xfer(1'b1, 8'h08, 32'h3, rd, ak);
      check("both_init", core_init_o, 1);
      check("both_no_next", core_next_o, 0);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("both_status", rd, 32'h0);
      xfer(1'b1, 8'h08, 32'h2, rd, ak);
      check("init_busy_no_next", core_next_o, 0);
      core_ready_i = 1'b1;
      tick(2);
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("both_done_status", rd, 32'h1);

      // Reset while waiting in NEXT
      xfer(1'b1, 8'h08, 32'h2, rd, ak);
      check("rn_next_pulse", core_next_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("rn_async_next", core_next_o, 0);
      check("rn_async_ack", bus.ack_o, 0);
      check("rn_async_key", core_key_o, 0);
      check("rn_async_block", core_block_o, 0);
      check("rn_async_cfg", {core_keylen_o, core_encdec_o}, 0);
      tick(1);
      rst_i = 1'b0;
      tick(1);
      core_result_i       = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
      core_result_valid_i = 1'b1;
      tick(1);
      core_result_valid_i = 1'b0;
      xfer(1'b0, 8'h09, 0, rd, ak);
      check("rn_status", rd, 32'h1);
      xfer(1'b0, 8'h30, 0, rd, ak);
      check("rn_result0", rd, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
